sig_frame_seq: RTL and testbench

Multi-frame SIGNAL-field sequencer for the OFDM transmit chain. It buffers up to `DEPTH` queued frame headers (type, length) and issues them to `TRANS` one frame at a time, using the `new_frame` / `sig_di_vld` pulse pair. It then tracks the transmitter's `do_vld` output stream to detect end-of-frame or timeout, and enforces a programmable inter-frame gap. It replaces the single-shot, hard-timed header injection with a synthesizable, back-to-back multi-frame source in the `pld_clk` domain.

---
 rtl/ofdm_pkg.sv | 20 ++
 rtl/hdr_fifo.sv | 57 +++++
 rtl/sig_frame_seq.sv | 172 +++++++++++++++++
 tb/tb_sig_frame_seq.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_pkg.sv
// Shared types for the OFDM transmit-chain SIGNAL-field sequencing logic.
package ofdm_pkg;

  localparam int TYPE_W_DEF = 4;
  localparam int LEN_W_DEF  = 16;

  typedef struct packed {
    logic [TYPE_W_DEF-1:0] typ;
    logic [LEN_W_DEF-1:0]  len;
  } sig_hdr_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_VLD  = 3'd2,
    ST_RUN  = 3'd3,
    ST_GAP  = 3'd4
  } frame_state_e;

endpackage

// File: rtl/hdr_fifo.sv
// Synchronous circular FIFO for queued frame headers, with registered level.
module hdr_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          rd_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q, level_d;
  logic          push, pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a write while full is accepted then.
  assign pop  = rd_i && !empty_o;
  assign push = wr_i && (!full_o || pop);

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + (AW+1)'(1);
    end else if (!push && pop) begin
      level_d = level_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      level_q <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/sig_frame_seq.sv
// Multi-frame SIGNAL-field sequencer: queues headers and issues them to TRANS one frame at a time.
//   state | meaning
//   IDLE  | waiting for enable and a queued header
//   HDR   | new_frame pulse, per-frame counters cleared
//   VLD   | sig_di_vld pulse
//   RUN   | counting tx_vld samples; end-of-frame or timeout detection
//   GAP   | programmable inter-frame gap
module sig_frame_seq
  import ofdm_pkg::*;
#(
  parameter int TYPE_W   = TYPE_W_DEF,
  parameter int LEN_W    = LEN_W_DEF,
  parameter int DEPTH    = 4,
  parameter int CNT_W    = 16,
  parameter int END_IDLE = 8,
  parameter int NF_W     = 8,
  localparam int LVL_W   = $clog2(DEPTH) + 1,
  localparam int SCNT_W  = LEN_W + 8
) (
  input  logic              pld_clk,
  input  logic              pld_rst,
  input  logic              enable,
  input  logic              hdr_wr,
  input  logic [TYPE_W-1:0] hdr_type,
  input  logic [LEN_W-1:0]  hdr_len,
  output logic              hdr_full,
  output logic [LVL_W-1:0]  hdr_level,
  input  logic [CNT_W-1:0]  cfg_gap,
  input  logic [CNT_W-1:0]  cfg_timeout,
  input  logic              tx_vld,
  output logic              new_frame,
  output logic [TYPE_W-1:0] sig_di_type,
  output logic [LEN_W-1:0]  sig_di_len,
  output logic              sig_di_vld,
  output logic              busy,
  output logic [NF_W-1:0]   frame_cnt,
  output logic [SCNT_W-1:0] sample_cnt,
  output logic              timeout_err
);

  localparam int HW = TYPE_W + LEN_W;

  frame_state_e      state_q, state_d;
  logic [TYPE_W-1:0] type_q, type_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [SCNT_W-1:0] sample_q, sample_d;
  logic [CNT_W-1:0]  idle_q, idle_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]  gap_q, gap_d;
  logic [NF_W-1:0]   fcnt_q, fcnt_d;
  logic              terr_q, terr_d;

  logic              fifo_rd;
  logic              fifo_empty;
  logic [HW-1:0]     fifo_head;

  hdr_fifo #(
    .W     (HW),
    .DEPTH (DEPTH)
  ) u_hdr_fifo (
    .clk_i   (pld_clk),
    .rst_i   (pld_rst),
    .wr_i    (hdr_wr),
    .wdata_i ({hdr_type, hdr_len}),
    .rd_i    (fifo_rd),
    .rdata_o (fifo_head),
    .full_o  (hdr_full),
    .empty_o (fifo_empty),
    .level_o (hdr_level)
  );

  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    len_d    = len_q;
    sample_d = sample_q;
    idle_d   = idle_q;
    wait_d   = wait_q;
    gap_d    = gap_q;
    fcnt_d   = fcnt_q;
    terr_d   = terr_q;
    fifo_rd  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable && !fifo_empty) begin
          fifo_rd = 1'b1;
          type_d  = fifo_head[LEN_W +: TYPE_W];
          len_d   = fifo_head[LEN_W-1:0];
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        sample_d = '0;
        idle_d   = '0;
        wait_d   = '0;
        state_d  = ST_VLD;
      end
      ST_VLD: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // A non-zero sample count doubles as the "first sample seen" flag since it saturates.
        if (tx_vld) begin
          if (sample_q != {SCNT_W{1'b1}}) sample_d = sample_q + SCNT_W'(1);
          idle_d = '0;
        end else if (sample_q != '0) begin
          if (idle_q == CNT_W'(END_IDLE - 1)) begin
            state_d = ST_GAP;
            gap_d   = cfg_gap;
            fcnt_d  = fcnt_q + NF_W'(1);
          end else begin
            idle_d = idle_q + CNT_W'(1);
          end
        end else if (cfg_timeout != '0) begin
          if (wait_q == cfg_timeout - CNT_W'(1)) begin
            state_d = ST_GAP;
            gap_d   = cfg_gap;
            terr_d  = 1'b1;
          end else begin
            wait_d = wait_q + CNT_W'(1);
          end
        end
      end
      ST_GAP: begin
        // Leaving on a count of 1 gives exactly cfg_gap cycles here, and 1 cycle for a gap of 0.
        if (gap_q <= CNT_W'(1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge pld_clk) begin
    if (pld_rst) begin
      state_q  <= ST_IDLE;
      type_q   <= '0;
      len_q    <= '0;
      sample_q <= '0;
      idle_q   <= '0;
      wait_q   <= '0;
      gap_q    <= '0;
      fcnt_q   <= '0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      len_q    <= len_d;
      sample_q <= sample_d;
      idle_q   <= idle_d;
      wait_q   <= wait_d;
      gap_q    <= gap_d;
      fcnt_q   <= fcnt_d;
      terr_q   <= terr_d;
    end
  end

  assign new_frame   = (state_q == ST_HDR);
  assign sig_di_vld  = (state_q == ST_VLD);
  assign busy        = (state_q != ST_IDLE);
  assign sig_di_type = type_q;
  assign sig_di_len  = len_q;
  assign frame_cnt   = fcnt_q;
  assign sample_cnt  = sample_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_sig_frame_seq.sv
// Scoreboard bench for sig_frame_seq: random headers and tx_vld patterns vs. a frame-level model.
`timescale 1ns/1ps
module tb_sig_frame_seq;
  import ofdm_pkg::*;

  localparam int DEPTH    = 4;
  localparam int END_IDLE = 8;

  logic        pld_clk = 1'b0;
  logic        pld_rst;
  logic        enable;
  logic        hdr_wr;
  logic [3:0]  hdr_type;
  logic [15:0] hdr_len;
  logic        hdr_full;
  logic [2:0]  hdr_level;
  logic [15:0] cfg_gap;
  logic [15:0] cfg_timeout;
  logic        tx_vld;
  logic        new_frame;
  logic [3:0]  sig_di_type;
  logic [15:0] sig_di_len;
  logic        sig_di_vld;
  logic        busy;
  logic [7:0]  frame_cnt;
  logic [23:0] sample_cnt;
  logic        timeout_err;

  sig_frame_seq #(
    .TYPE_W(4), .LEN_W(16), .DEPTH(DEPTH), .CNT_W(16), .END_IDLE(END_IDLE), .NF_W(8)
  ) dut (
    .pld_clk(pld_clk), .pld_rst(pld_rst), .enable(enable),
    .hdr_wr(hdr_wr), .hdr_type(hdr_type), .hdr_len(hdr_len),
    .hdr_full(hdr_full), .hdr_level(hdr_level),
    .cfg_gap(cfg_gap), .cfg_timeout(cfg_timeout), .tx_vld(tx_vld),
    .new_frame(new_frame), .sig_di_type(sig_di_type), .sig_di_len(sig_di_len),
    .sig_di_vld(sig_di_vld), .busy(busy), .frame_cnt(frame_cnt),
    .sample_cnt(sample_cnt), .timeout_err(timeout_err)
  );

  always #5 pld_clk = ~pld_clk;

  typedef struct {
    int samples;
    int fcnt;
    bit terr;
    int dur;
  } res_t;

  sig_hdr_t exp_hdr_q[$];
  res_t     res_q[$];
  int       mode_q[$];

  int checks = 0;
  int errors = 0;
  int model_level = 0;
  int model_fcnt  = 0;
  bit model_terr  = 0;
  int nf_seen     = 0;
  bit abort       = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_new_frame"},   new_frame,   0);
    check({tag, "_sig_di_vld"},  sig_di_vld,  0);
    check({tag, "_sig_di_type"}, sig_di_type, 0);
    check({tag, "_sig_di_len"},  sig_di_len,  0);
    check({tag, "_busy"},        busy,        0);
    check({tag, "_frame_cnt"},   frame_cnt,   0);
    check({tag, "_sample_cnt"},  sample_cnt,  0);
    check({tag, "_timeout_err"}, timeout_err, 0);
    check({tag, "_hdr_full"},    hdr_full,    0);
    check({tag, "_hdr_level"},   hdr_level,   0);
  endtask

  // with_pop: push in the same cycle enable rises while the FSM is idle and the queue is full.
  task automatic push_hdr(input logic [3:0] t, input logic [15:0] l, input bit with_pop);
    sig_hdr_t h;
    @(negedge pld_clk);
    hdr_wr = 1'b1; hdr_type = t; hdr_len = l;
    if (with_pop) enable = 1'b1;
    if (model_level < DEPTH || with_pop) begin
      h.typ = t; h.len = l;
      exp_hdr_q.push_back(h);
      if (!with_pop) model_level++;
    end
    @(negedge pld_clk);
    hdr_wr = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge pld_clk);
      n++;
    end while (!(exp_hdr_q.size() == 0 && res_q.size() == 0 && !busy && hdr_level == 0) && n < 4000);
    checks++;
    if (n >= 4000) begin
      errors++;
      $display("FAIL drain_%s: queue not drained, hdr left %0d, results left %0d, busy %0b",
               tag, exp_hdr_q.size(), res_q.size(), busy);
    end
    model_level = 0;
  endtask

  // tx_vld driver: builds a per-frame pattern and predicts the frame outcome from it.
  initial begin
    bit pat[$];
    int m, lead, last, ones, run_len, gapc, nb;
    bit tmo;
    res_t r;
    tx_vld = 1'b0;
    forever begin
      @(negedge pld_clk);
      if (sig_di_vld && !abort) begin
        m = (mode_q.size() != 0) ? mode_q.pop_front() : 0;
        pat.delete();
        case (m)
          1: repeat (80) pat.push_back(1'b1);
          2: ;
          3: begin
            repeat (10) pat.push_back(1'b1);
            repeat (7)  pat.push_back(1'b0);
            repeat (10) pat.push_back(1'b1);
          end
          4: pat.push_back(1'b1);
          default: begin
            repeat ($urandom_range(0, 3)) pat.push_back(1'b0);
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
              if (b > 0) repeat ($urandom_range(1, END_IDLE - 1)) pat.push_back(1'b0);
              repeat ($urandom_range(1, 15)) pat.push_back(1'b1);
            end
          end
        endcase
        lead = 1 << 30; last = -1; ones = 0;
        for (int i = 0; i < pat.size(); i++) begin
          if (pat[i]) begin
            if (lead == (1 << 30)) lead = i;
            last = i;
            ones++;
          end
        end
        tmo = (cfg_timeout != 0) && (lead >= int'(cfg_timeout));
        if (tmo) begin
          run_len = int'(cfg_timeout);
          r.samples = 0;
          model_terr = 1'b1;
        end else begin
          run_len = last + 1 + END_IDLE;
          r.samples = ones;
          model_fcnt = (model_fcnt + 1) % 256;
        end
        gapc = (cfg_gap == 0) ? 1 : int'(cfg_gap);
        r.fcnt = model_fcnt;
        r.terr = model_terr;
        r.dur  = run_len + gapc + 1;
        res_q.push_back(r);
        tx_vld = 1'b0;
        if (!tmo) begin
          for (int i = 0; i < pat.size(); i++) begin
            @(negedge pld_clk);
            if (abort) break;
            tx_vld = pat[i];
          end
        end
        @(negedge pld_clk);
        tx_vld = 1'b0;
      end
    end
  end

  // Monitor: header order on new_frame, frame outcome and duration when busy falls.
  initial begin
    sig_hdr_t h;
    res_t r;
    bit busy_prev;
    int cyc;
    logic [3:0] held_t;
    busy_prev = 1'b0;
    cyc = -1;
    held_t = '0;
    forever begin
      @(negedge pld_clk);
      if (abort || pld_rst) begin
        busy_prev = 1'b0;
        cyc = -1;
      end else begin
        if (new_frame) begin
          nf_seen++;
          check("nf_vld_overlap", sig_di_vld, 0);
          if (exp_hdr_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_frame: actual type %0d len %0d, required no frame", sig_di_type, sig_di_len);
          end else begin
            h = exp_hdr_q.pop_front();
            check("hdr_type", sig_di_type, h.typ);
            check("hdr_len", sig_di_len, h.len);
            held_t = h.typ;
          end
        end
        if (sig_di_vld) begin
          check("vld_type_held", sig_di_type, held_t);
          cyc = 0;
        end else if (cyc >= 0) begin
          cyc++;
        end
        if (busy_prev && !busy) begin
          if (res_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_frame_end: actual frame end, required none");
          end else begin
            r = res_q.pop_front();
            check("sample_cnt", sample_cnt, r.samples);
            check("frame_cnt", frame_cnt, r.fcnt);
            check("timeout_err", timeout_err, r.terr);
            check("frame_duration", cyc, r.dur);
          end
          cyc = -1;
        end
        busy_prev = busy;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: actual time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nf;
    pld_rst = 1'b1; enable = 1'b0; hdr_wr = 1'b0; hdr_type = '0; hdr_len = '0;
    cfg_gap = '0; cfg_timeout = '0;
    repeat (3) @(negedge pld_clk);
    check_all_zero("reset");
    pld_rst = 1'b0;

    // single frame with exact header latency
    cfg_gap = 16'd5; enable = 1'b1;
    mode_q.push_back(1);
    push_hdr(4'hB, 16'd100, 1'b0);
    check("lat_t1_new_frame", new_frame, 0);
    check("lat_t1_level", hdr_level, 1);
    @(negedge pld_clk);
    check("lat_t2_new_frame", new_frame, 1);
    check("lat_t2_vld", sig_di_vld, 0);
    @(negedge pld_clk);
    check("lat_t3_vld", sig_di_vld, 1);
    check("lat_t3_new_frame", new_frame, 0);
    drain("single");

    // back-to-back: fill, drop on full, then push alongside the first pop
    enable = 1'b0;
    cfg_gap = 16'($urandom_range(0, 6));
    repeat (5) push_hdr(4'($urandom), 16'($urandom), 1'b0);
    check("full_flag", hdr_full, 1);
    check("full_level", hdr_level, model_level);
    push_hdr(4'($urandom), 16'($urandom), 1'b1);
    check("push_pop_full_level", hdr_level, DEPTH);
    check("push_pop_full_flag", hdr_full, 1);
    drain("b2b");

    // timeout followed by a normal frame
    enable = 1'b0; cfg_timeout = 16'd50; cfg_gap = 16'd2;
    mode_q.push_back(2); mode_q.push_back(0);
    repeat (2) push_hdr(4'($urandom), 16'($urandom), 1'b0);
    enable = 1'b1;
    drain("timeout");
    check("timeout_sticky", timeout_err, model_terr);

    // idle glitch shorter than END_IDLE stays in one frame
    mode_q.push_back(3);
    push_hdr(4'($urandom), 16'($urandom), 1'b0);
    drain("glitch");

    // enable low holds headers; reset mid-RUN aborts and empties the queue
    enable = 1'b0;
    mode_q.push_back(1); mode_q.push_back(1);
    repeat (2) push_hdr(4'($urandom), 16'($urandom), 1'b0);
    nf = nf_seen;
    repeat (30) @(negedge pld_clk);
    check("disabled_no_frame", nf_seen, nf);
    check("disabled_level", hdr_level, model_level);
    check("disabled_busy", busy, 0);
    enable = 1'b1;
    begin
      int n;
      n = 0;
      while (!sig_di_vld && n < 20) begin
        @(negedge pld_clk);
        n++;
      end
      check("enable_start", sig_di_vld, 1);
    end
    repeat (6) @(negedge pld_clk);
    check("mid_run_busy", busy, 1);
    abort = 1'b1; pld_rst = 1'b1;
    @(negedge pld_clk);
    check_all_zero("midrun_reset");
    pld_rst = 1'b0;
    exp_hdr_q.delete(); res_q.delete(); mode_q.delete();
    model_level = 0; model_fcnt = 0; model_terr = 1'b0;
    nf = nf_seen;
    repeat (10) @(negedge pld_clk);
    check("post_reset_no_frame", nf_seen, nf);
    check("post_reset_busy", busy, 0);
    abort = 1'b0;

    // 256 short frames: frame counter and FIFO pointers wrap
    cfg_gap = 16'd0;
    for (int b = 0; b < 64; b++) begin
      enable = 1'b0;
      repeat (4) begin
        mode_q.push_back(4);
        push_hdr(4'($urandom), 16'($urandom), 1'b0);
      end
      enable = 1'b1;
      drain("wrap");
    end
    check("wrap_frame_cnt", frame_cnt, model_fcnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
